// File: rtl/sdram_init_sequencer_pkg.sv
// Shared encodings for the SDRAM power-up / refresh sequencer.
// Commands are packed as {CSn, RASn, CASn, WEn}.
package sdram_init_sequencer_pkg;

  localparam logic [3:0] ST_WAIT_LOCK = 4'd0;
  localparam logic [3:0] ST_PWRUP     = 4'd1;
  localparam logic [3:0] ST_I_PRE     = 4'd2;
  localparam logic [3:0] ST_I_REF     = 4'd3;
  localparam logic [3:0] ST_I_MRS     = 4'd4;
  localparam logic [3:0] ST_IDLE      = 4'd5;
  localparam logic [3:0] ST_R_WAIT    = 4'd6;
  localparam logic [3:0] ST_R_PRE     = 4'd7;
  localparam logic [3:0] ST_R_AR      = 4'd8;
  localparam logic [3:0] ST_R_REL     = 4'd9;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_INH = 4'b1111;

  localparam int A10_BIT = 10;

  localparam logic [3:0] PEND_MAX = 4'd8;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval counter with a saturating backlog of owed refreshes.
// Ticks every pREFRESH_CYCLES while enabled; all state clears when disabled.
module sdram_refresh_timer
  import sdram_init_sequencer_pkg::*;
#(
  parameter int pREFRESH_CYCLES = 1500
)
(
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iENABLE,
  input  logic iCONSUME,
  output logic oPENDING_NZ,
  output logic oOVERRUN
);

  localparam int TW = $clog2(pREFRESH_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(pREFRESH_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          tick;

  always_comb begin
    tick   = (tmr_q == TMR_LAST);
    tmr_d  = tick ? '0 : tmr_q + 1'b1;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    // A tick coinciding with a consume cancels out.
    if (tick && !iCONSUME) begin
      if (pend_q == PEND_MAX) ovr_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (iCONSUME && !tick && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
    if (!iENABLE) begin
      tmr_d  = '0;
      pend_d = '0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      tmr_q  <= '0;
      pend_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign oPENDING_NZ = (pend_q != '0);
  assign oOVERRUN    = ovr_q;

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up init and periodic AUTO REFRESH owner of the command bus.
// All pins registered; refresh waits on iREF_ACK before taking the bus.
module sdram_init_sequencer
  import sdram_init_sequencer_pkg::*;
#(
  parameter int          pINIT_CYCLES    = 20000,
  parameter int          pREFRESH_CYCLES = 1500,
  parameter int          pTRP            = 3,
  parameter int          pTRFC           = 9,
  parameter int          pTMRD           = 2,
  parameter logic [11:0] pMODE           = 12'h033
)
(
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iPLL_LOCKED,
  input  logic        iREF_ACK,
  output logic        oREF_REQ,
  output logic        oINIT_DONE,
  output logic        oBUS_OWN,
  output logic        oREF_OVERRUN,
  output logic        oSDRAM_CKE,
  output logic        oSDRAM_CSn,
  output logic        oSDRAM_RASn,
  output logic        oSDRAM_CASn,
  output logic        oSDRAM_WEn,
  output logic [11:0] oSDRAM_ADDR,
  output logic [1:0]  oSDRAM_BA
);

  localparam int CW = $clog2(pINIT_CYCLES + 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          second_q, second_d;
  logic          cke_q, cke_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [11:0]   addr_q, addr_d;
  logic          done_q, done_d;
  logic          own_q, own_d;
  logic          req_q, req_d;
  logic          wait_done, consume, pending_nz, tmr_en;

  assign wait_done = (cnt_q == '0);
  assign tmr_en    = done_q && iPLL_LOCKED;

  sdram_refresh_timer #(
    .pREFRESH_CYCLES (pREFRESH_CYCLES)
  ) u_timer (
    .iCLK        (iCLK),
    .iRESETn     (iRESETn),
    .iENABLE     (tmr_en),
    .iCONSUME    (consume),
    .oPENDING_NZ (pending_nz),
    .oOVERRUN    (oREF_OVERRUN)
  );

  // Next-state logic also produces the command to register onto the pins,
  // so pin activity lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = wait_done ? cnt_q : cnt_q - 1'b1;
    second_d = second_q;
    cke_d    = cke_q;
    done_d   = done_q;
    own_d    = own_q;
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    consume  = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        cmd_d = CMD_INH;
        if (iPLL_LOCKED) begin
          state_d = ST_PWRUP;
          cnt_d   = CW'(pINIT_CYCLES - 1);
          cke_d   = 1'b1;
          cmd_d   = CMD_NOP;
        end
      end
      ST_PWRUP: if (wait_done) begin
        state_d         = ST_I_PRE;
        cnt_d           = CW'(pTRP);
        cmd_d           = CMD_PRE;
        addr_d[A10_BIT] = 1'b1;
      end
      ST_I_PRE: if (wait_done) begin
        state_d  = ST_I_REF;
        cnt_d    = CW'(pTRFC);
        cmd_d    = CMD_REF;
        second_d = 1'b0;
      end
      ST_I_REF: if (wait_done) begin
        if (!second_q) begin
          cnt_d    = CW'(pTRFC);
          cmd_d    = CMD_REF;
          second_d = 1'b1;
        end else begin
          state_d = ST_I_MRS;
          cnt_d   = CW'(pTMRD);
          cmd_d   = CMD_MRS;
          addr_d  = pMODE;
        end
      end
      ST_I_MRS: if (wait_done) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        own_d   = 1'b0;
      end
      ST_IDLE: if (pending_nz) state_d = ST_R_WAIT;
      ST_R_WAIT: if (iREF_ACK) begin
        state_d         = ST_R_PRE;
        cnt_d           = CW'(pTRP);
        own_d           = 1'b1;
        cmd_d           = CMD_PRE;
        addr_d[A10_BIT] = 1'b1;
      end
      ST_R_PRE: if (wait_done) begin
        state_d = ST_R_AR;
        cnt_d   = CW'(pTRFC);
        cmd_d   = CMD_REF;
        consume = 1'b1;
      end
      ST_R_AR: if (wait_done) begin
        state_d = ST_R_REL;
        own_d   = 1'b0;
      end
      ST_R_REL: if (!iREF_ACK) state_d = ST_IDLE;
      default: state_d = ST_WAIT_LOCK;
    endcase
    // Losing the clock source voids the device state: back to square one.
    if (!iPLL_LOCKED) begin
      state_d  = ST_WAIT_LOCK;
      cnt_d    = '0;
      second_d = 1'b0;
      cke_d    = 1'b0;
      done_d   = 1'b0;
      own_d    = 1'b1;
      cmd_d    = CMD_INH;
      addr_d   = '0;
      consume  = 1'b0;
    end
    req_d = pending_nz && (state_d == ST_IDLE || state_d == ST_R_WAIT);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      second_q <= 1'b0;
      cke_q    <= 1'b0;
      cmd_q    <= CMD_INH;
      addr_q   <= '0;
      done_q   <= 1'b0;
      own_q    <= 1'b1;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      second_q <= second_d;
      cke_q    <= cke_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      own_q    <= own_d;
      req_q    <= req_d;
    end
  end

  assign oSDRAM_CKE  = cke_q;
  assign oSDRAM_CSn  = cmd_q[3];
  assign oSDRAM_RASn = cmd_q[2];
  assign oSDRAM_CASn = cmd_q[1];
  assign oSDRAM_WEn  = cmd_q[0];
  assign oSDRAM_ADDR = addr_q;
  assign oSDRAM_BA   = 2'b00;
  assign oINIT_DONE  = done_q;
  assign oBUS_OWN    = own_q;
  assign oREF_REQ    = req_q;

endmodule
